// File: rtl/obstacle_spawner.sv
// obstacle_spawner: scroll-tick generator and obstacle slot spawner.
//  - upsig: registered one-cycle scroll tick, period BASE_PERIOD >> (speed-1).
//  - Every SPAWN_GAP ticks the lowest free slot gets a one-cycle init pulse
//    together with a pseudo-random lane x-position.
// Optional build macro NO_REPEAT_LANE_EN: consecutive spawns never share a lane.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | game disabled, gap counter frozen
// S_WAIT  | counting scroll ticks towards SPAWN_GAP
// S_PICK  | gap expired, inspect free slots
// S_FULL  | every slot busy, re-check every cycle
// S_SPAWN | init pulse is on the outputs this cycle
module obstacle_spawner #(
   parameter int NUM_SLOTS   = 4,
   parameter int BASE_PERIOD = 262144,
   parameter int SPAWN_GAP   = 120,
   parameter int X_MIN       = 40,
   parameter int LANE_W      = 32
) (
   input  logic                 clk,
   input  logic                 init_n,
   input  logic                 enable,
   input  logic [2:0]           speed,
   input  logic [NUM_SLOTS-1:0] slot_on,
   output logic                 upsig,
   output logic [NUM_SLOTS-1:0] slot_init,
   output logic [7:0]           initial_x,
   output logic [7:0]           spawn_count
);

   localparam int          PW         = $clog2(BASE_PERIOD + 1);
   localparam logic [15:0] LFSR_SEED  = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS  = 16'hB400;
   localparam logic [7:0]  GAP_TARGET = 8'(SPAWN_GAP);
   localparam logic [7:0]  X_BASE     = 8'(X_MIN);
   localparam logic [7:0]  X_STEP     = 8'(LANE_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_PICK,
      S_FULL,
      S_SPAWN
   } state_t;

   state_t               state;
   logic [PW-1:0]        prescaler;
   logic [PW-1:0]        period;
   logic [PW-1:0]        period_m1;
   logic                 tick_run;
   logic [15:0]          lfsr;
   logic [7:0]           gap;
   logic [7:0]           gap_inc;
   logic [1:0]           lane_raw;
   logic [1:0]           lane;
   logic [7:0]           lane_x;
   logic [NUM_SLOTS-1:0] free_slots;
   logic [NUM_SLOTS-1:0] pick_onehot;
   logic [7:0]           count_inc;

   // Current tick period; very small periods (only reachable with tiny
   // BASE_PERIOD) are clamped to one cycle so the compare never underflows.
   always_comb begin
      period    = PW'(BASE_PERIOD) >> (speed - 3'd1);
      period_m1 = (period == '0) ? '0 : period - PW'(1);
      tick_run  = enable && (speed != 3'd0);
   end

   // Prescaler and registered scroll tick; >= lets a shortened period fire at once.
   always_ff @(posedge clk) begin
      if (!init_n) begin
         prescaler <= '0;
         upsig     <= 1'b0;
      end else if (tick_run) begin
         if (prescaler >= period_m1) begin
            prescaler <= '0;
            upsig     <= 1'b1;
         end else begin
            prescaler <= prescaler + PW'(1);
            upsig     <= 1'b0;
         end
      end else begin
         upsig <= 1'b0;
      end
   end

   // Free-running Galois LFSR, x^16+x^14+x^13+x^11; seeded non-zero so it never locks up.
   always_ff @(posedge clk) begin
      if (!init_n) begin
         lfsr <= LFSR_SEED;
      end else if (lfsr[0]) begin
         lfsr <= (lfsr >> 1) ^ LFSR_TAPS;
      end else begin
         lfsr <= lfsr >> 1;
      end
   end

   assign lane_raw = lfsr[1:0];

`ifdef NO_REPEAT_LANE_EN
   logic [1:0] last_lane;
   assign lane = (lane_raw == last_lane) ? lane_raw + 2'd1 : lane_raw;
`else
   assign lane = lane_raw;
`endif

   assign lane_x      = X_BASE + ({6'd0, lane} * X_STEP);
   assign free_slots  = ~slot_on;
   // Two's-complement trick isolates the lowest set bit of the free mask.
   assign pick_onehot = free_slots & (~free_slots + NUM_SLOTS'(1));
   assign gap_inc     = (upsig && (gap != 8'hFF)) ? gap + 8'd1 : gap;
   assign count_inc   = (spawn_count == 8'hFF) ? spawn_count : spawn_count + 8'd1;

   // Spawn sequencer; the init pulse is registered on the edge entering S_SPAWN.
   always_ff @(posedge clk) begin
      if (!init_n) begin
         state       <= S_IDLE;
         gap         <= 8'd0;
         slot_init   <= '0;
         initial_x   <= X_BASE;
         spawn_count <= 8'd0;
`ifdef NO_REPEAT_LANE_EN
         last_lane   <= 2'd0;
`endif
      end else begin
         slot_init <= '0;
         case (state)
            S_IDLE: begin
               if (enable) begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (!enable) begin
                  gap   <= gap_inc;
                  state <= S_IDLE;
               end else if (gap_inc >= GAP_TARGET) begin
                  gap   <= 8'd0;
                  state <= S_PICK;
               end else begin
                  gap <= gap_inc;
               end
            end
            S_PICK, S_FULL: begin
               // Ticks arriving while a spawn is pending still count toward the next gap.
               gap <= gap_inc;
               if (!enable) begin
                  state <= S_IDLE;
               end else if (free_slots != '0) begin
                  slot_init   <= pick_onehot;
                  initial_x   <= lane_x;
                  spawn_count <= count_inc;
`ifdef NO_REPEAT_LANE_EN
                  last_lane   <= lane;
`endif
                  state       <= S_SPAWN;
               end else begin
                  state <= S_FULL;
               end
            end
            S_SPAWN: begin
               gap   <= gap_inc;
               state <= enable ? S_WAIT : S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed plus randomized bench for obstacle_spawner (BASE_PERIOD=16, SPAWN_GAP=3).
module tb_obstacle_spawner;

   logic       clk;
   logic       init_n;
   logic       enable;
   logic [2:0] speed;
   logic [3:0] slot_on;
   logic       upsig;
   logic [3:0] slot_init;
   logic [7:0] initial_x;
   logic [7:0] spawn_count;

   int errors = 0;
   int checks = 0;

   obstacle_spawner #(
      .NUM_SLOTS  (4),
      .BASE_PERIOD(16),
      .SPAWN_GAP  (3),
      .X_MIN      (40),
      .LANE_W     (32)
   ) dut (
      .clk        (clk),
      .init_n     (init_n),
      .enable     (enable),
      .speed      (speed),
      .slot_on    (slot_on),
      .upsig      (upsig),
      .slot_init  (slot_init),
      .initial_x  (initial_x),
      .spawn_count(spawn_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected tick period from the rate rule, clamped to one cycle.
   function automatic int exp_period(input int s);
      int p;
      p = 16 >> (s - 1);
      return (p < 1) ? 1 : p;
   endfunction

   function automatic logic [3:0] lowest_free(input logic [3:0] occ);
      for (int i = 0; i < 4; i++) begin
         if (!occ[i]) return 4'(1 << i);
      end
      return 4'd0;
   endfunction

   function automatic logic in_lanes(input logic [7:0] x);
      return (x == 8'd40) || (x == 8'd72) || (x == 8'd104) || (x == 8'd136);
   endfunction

   task automatic wait_up(input string tag, input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (upsig !== 1'b1 && n < budget);
      chk({tag, "_seen"}, 32'(upsig), 32'd1);
   endtask

   task automatic wait_pulse(input string tag, input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (slot_init === 4'd0 && n < budget);
      chk({tag, "_seen"}, 32'(slot_init != 4'd0), 32'd1);
   endtask

   initial begin
      int         n;
      int         lat;
      int         cnt_up;
      int         cnt_pulse;
      int         s;
      int         exp_cnt;
      int         npulse;
      int         repeats;
      int         bad_x;
      logic [3:0] occ;
      logic [7:0] x_seen;
      logic [7:0] prev_x;

      // 1. reset values
      init_n  = 1'b0;
      enable  = 1'b0;
      speed   = 3'd0;
      slot_on = 4'b0000;
      repeat (2) @(negedge clk);
      chk("rst_upsig", 32'(upsig), 32'd0);
      chk("rst_slot_init", 32'(slot_init), 32'd0);
      chk("rst_initial_x", 32'(initial_x), 32'd40);
      chk("rst_spawn_count", 32'(spawn_count), 32'd0);

      init_n = 1'b1;
      enable = 1'b1;
      speed  = 3'd1;
      wait_up("first_tick", 40, n);
      chk("first_tick_delay", 32'(n), 32'd16);
      wait_up("tick2", 40, n);
      chk("tick2_period", 32'(n), 32'd16);
      wait_up("tick3", 40, n);
      chk("tick3_period", 32'(n), 32'd16);

      // 3. third tick expires the gap; slots all free
      wait_pulse("first_spawn", 4, lat);
      chk("first_spawn_latency_ok", 32'(lat >= 1 && lat <= 2), 32'd1);
      chk("first_spawn_slot", 32'(slot_init), 32'b0001);
      chk("first_spawn_x_lane", 32'(in_lanes(initial_x)), 32'd1);
      chk("first_spawn_count", 32'(spawn_count), 32'd1);
      x_seen = initial_x;
      @(negedge clk);
      chk("pulse_one_cycle", 32'(slot_init), 32'd0);
      chk("initial_x_hold", 32'(initial_x), 32'(x_seen));

      // 2. rate changes
      speed = 3'd3;
      wait_up("s3_sync", 40, n);
      wait_up("s3_a", 40, n);
      chk("s3_period_a", 32'(n), 32'd4);
      wait_up("s3_b", 40, n);
      chk("s3_period_b", 32'(n), 32'd4);
      speed = 3'd1;
      repeat (10) @(negedge clk);
      speed = 3'd4;
      wait_up("s4_early", 40, n);
      chk("s4_early_tick", 32'(n), 32'd1);
      wait_up("s4_a", 40, n);
      chk("s4_period_a", 32'(n), 32'd2);
      wait_up("s4_b", 40, n);
      chk("s4_period_b", 32'(n), 32'd2);

      // 4. all slots busy, then one frees
      wait_pulse("pre_full", 40, lat);
      slot_on   = 4'b1111;
      cnt_pulse = 0;
      repeat (20) begin
         @(negedge clk);
         if (slot_init !== 4'd0) cnt_pulse++;
      end
      chk("full_no_pulse", 32'(cnt_pulse), 32'd0);
      slot_on = 4'b1011;
      wait_pulse("full_release", 2, lat);
      chk("full_release_slot", 32'(slot_init), 32'b0100);

      // 5. disable mid-WAIT, gap count must resume
      speed   = 3'd1;
      slot_on = 4'b0000;
      wait_pulse("s5_pulse_a", 100, lat);
      wait_pulse("s5_pulse_b", 100, lat);
      wait_up("s5_tick1", 40, n);
      @(negedge clk);
      enable    = 1'b0;
      cnt_up    = 0;
      cnt_pulse = 0;
      repeat (50) begin
         @(negedge clk);
         if (upsig === 1'b1) cnt_up++;
         if (slot_init !== 4'd0) cnt_pulse++;
      end
      chk("disabled_no_upsig", 32'(cnt_up), 32'd0);
      chk("disabled_no_pulse", 32'(cnt_pulse), 32'd0);
      enable = 1'b1;
      cnt_up = 0;
      n      = 0;
      do begin
         @(negedge clk);
         n++;
         if (upsig === 1'b1) cnt_up++;
      end while (slot_init === 4'd0 && n < 100);
      chk("resume_pulse_seen", 32'(slot_init != 4'd0), 32'd1);
      chk("resume_ticks_to_spawn", 32'(cnt_up), 32'd2);

      // reset arriving during SPAWN
      wait_pulse("pre_reset", 100, lat);
      init_n = 1'b0;
      @(negedge clk);
      chk("midspawn_rst_slot_init", 32'(slot_init), 32'd0);
      chk("midspawn_rst_count", 32'(spawn_count), 32'd0);
      chk("midspawn_rst_x", 32'(initial_x), 32'd40);
      chk("midspawn_rst_upsig", 32'(upsig), 32'd0);

      // randomized rates and occupancy against the rule-level model
      init_n  = 1'b1;
      enable  = 1'b1;
      exp_cnt = 0;
      for (int it = 0; it < 12; it++) begin
         slot_on = 4'b1111;
         s       = int'($urandom_range(1, 5));
         speed   = 3'(s);
         wait_up("rnd_sync", 40, n);
         wait_up("rnd_tick", 40, n);
         chk("rnd_tick_period", 32'(n), 32'(exp_period(s)));
         occ     = 4'($urandom_range(0, 14));
         slot_on = occ;
         wait_pulse("rnd_spawn", 200, lat);
         exp_cnt++;
         chk("rnd_spawn_slot", 32'(slot_init), 32'(lowest_free(occ)));
         chk("rnd_spawn_x_lane", 32'(in_lanes(initial_x)), 32'd1);
         chk("rnd_spawn_count", 32'(spawn_count), 32'(exp_cnt));
         x_seen  = initial_x;
         slot_on = 4'b1111;
         @(negedge clk);
         chk("rnd_x_hold", 32'(initial_x), 32'(x_seen));
      end

      // 6. long run: lane repetition rule and saturation
      slot_on = 4'b0000;
      speed   = 3'd5;
      npulse  = 0;
      repeats = 0;
      bad_x   = 0;
      prev_x  = 8'd0;
      n       = 0;
      while (npulse < 300 && n < 6000) begin
         @(negedge clk);
         n++;
         if (slot_init !== 4'd0) begin
            if (!in_lanes(initial_x)) bad_x++;
            if (npulse > 0 && initial_x == prev_x) repeats++;
            prev_x = initial_x;
            npulse++;
         end
      end
      chk("long_run_pulses", 32'(npulse), 32'd300);
      chk("long_run_bad_x", 32'(bad_x), 32'd0);
      chk("spawn_count_saturated", 32'(spawn_count), 32'd255);
`ifdef NO_REPEAT_LANE_EN
      chk("no_consecutive_repeat", 32'(repeats), 32'd0);
`else
      chk("repeat_observed", 32'(repeats > 0), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
